// File: rtl/punc_mc_control_if.sv
// -----------------------------------------------------------------------------
// punc_mc_control_if
//   Memory handshake bundle between the PUnC control unit and the memory
//   wrapper.
//   mem_req      : access request, held until mem_ready
//   mem_we       : write enable, stable for the whole request
//   mem_addr_sel : address source (0 PC, 1 PC+off9, 2 Rq+off6, 3 temp)
//   mem_ready    : memory completes the current access this cycle
//   master modport = control unit, slave modport = memory wrapper.
// -----------------------------------------------------------------------------
interface punc_mc_control_if;
  logic       mem_req;
  logic       mem_we;
  logic [1:0] mem_addr_sel;
  logic       mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/punc_mc_control.sv
// -----------------------------------------------------------------------------
// punc_mc_control
//   Multicycle control unit for the PUnC LC3 core with variable-latency
//   memory. Sequences INIT/FETCH/DECODE/EXEC/EXEC2/HALT/FAULT, decodes ir and
//   drives the datapath strobes. Every memory access waits on mem_ready; a
//   stuck access longer than TIMEOUT_CYCLES traps the core in FAULT.
//
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     ir, nzp_match     : instruction and branch condition from the datapath
//     run               : resume from HALT
//     mem               : memory handshake (punc_mc_control_if.master)
//     ir_/pc_/rf_/alu_/temp_/nzp_* : datapath control strobes and selects
//     halted, fault     : status
//     instr_count, stall_count : performance counters
//
//   Build option: define PUNC_CTRL_PERF_EN to build the instruction/stall
//   counters; otherwise both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module punc_mc_control #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ir,
  input  logic             nzp_match,
  input  logic             run,
  punc_mc_control_if.master mem,
  output logic             ir_clr,
  output logic             ir_ld,
  output logic             pc_clr,
  output logic             pc_ld,
  output logic             pc_inc,
  output logic [1:0]       pc_sel,
  output logic [1:0]       rf_w_data_sel,
  output logic             rf_w_addr_sel,
  output logic             rf_rp_addr_sel,
  output logic             rf_w_wr,
  output logic             rf_rp_rd,
  output logic             rf_rq_rd,
  output logic             temp_ld,
  output logic             nzp_ld,
  output logic             nzp_clr,
  output logic [1:0]       alu_sel,
  output logic             alu_in_a,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [2:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_HALT, S_FAULT
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010,
                         OP_ST  = 4'b0011, OP_JSR = 4'b0100, OP_AND = 4'b0101,
                         OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001,
                         OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                         OP_LEA = 4'b1110, OP_HLT = 4'b1111;

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES > 0) ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_req, mem_we;
  logic [1:0]        mem_addr_sel;
  logic              timeout_hit;
  logic              stalled;
  logic [3:0]        opcode;
  logic              unused_ir;

  assign opcode      = ir[15:12];
  assign unused_ir   = ^{ir[10:6], ir[4:0]};
  assign stalled     = mem_req && !mem.mem_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == WAIT_LAST);

  assign mem.mem_req      = mem_req;
  assign mem.mem_we       = mem_we;
  assign mem.mem_addr_sel = mem_addr_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Wait counter restarts whenever the FSM moves, so each access gets its own
  // timeout budget.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q)
      wait_cnt_d = '0;
    else if (stalled && (TIMEOUT_CYCLES != 0))
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
  end

  always_comb begin
    state_d        = state_q;
    ir_clr         = 1'b0;
    ir_ld          = 1'b0;
    pc_clr         = 1'b0;
    pc_ld          = 1'b0;
    pc_inc         = 1'b0;
    pc_sel         = 2'd0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr_sel   = 2'd0;
    rf_w_data_sel  = 2'd0;
    rf_w_addr_sel  = 1'b0;
    rf_rp_addr_sel = 1'b0;
    rf_w_wr        = 1'b0;
    rf_rp_rd       = 1'b0;
    rf_rq_rd       = 1'b0;
    temp_ld        = 1'b0;
    nzp_ld         = 1'b0;
    nzp_clr        = 1'b0;
    alu_sel        = 2'd0;
    alu_in_a       = 1'b0;
    halted         = 1'b0;
    fault          = 1'b0;

    unique case (state_q)
      S_INIT: begin
        pc_clr  = 1'b1;
        ir_clr  = 1'b1;
        nzp_clr = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_ADD, OP_AND: begin
            alu_sel  = (opcode == OP_AND) ? 2'd1 : 2'd0;
            rf_w_wr  = 1'b1;
            nzp_ld   = 1'b1;
            rf_rq_rd = 1'b1;
            if (ir[5]) alu_in_a = 1'b1;
            else       rf_rp_rd = 1'b1;
          end
          OP_NOT: begin
            alu_sel  = 2'd2;
            rf_rq_rd = 1'b1;
            rf_w_wr  = 1'b1;
            nzp_ld   = 1'b1;
          end
          OP_LEA: begin
            rf_w_data_sel = 2'd3;
            rf_w_wr       = 1'b1;
            nzp_ld        = 1'b1;
          end
          OP_BR: pc_ld = nzp_match;
          OP_JMP: begin
            rf_rq_rd = 1'b1;
            pc_ld    = 1'b1;
            pc_sel   = 2'd2;
          end
          OP_JSR: begin
            rf_w_data_sel = 2'd2;
            rf_w_addr_sel = 1'b1;
            rf_w_wr       = 1'b1;
            state_d       = S_EXEC2;
          end
          OP_LD, OP_LDR: begin
            mem_req       = 1'b1;
            mem_addr_sel  = (opcode == OP_LD) ? 2'd1 : 2'd2;
            rf_rq_rd      = (opcode == OP_LDR);
            rf_w_data_sel = 2'd1;
            rf_w_wr       = mem.mem_ready;
            nzp_ld        = mem.mem_ready;
            state_d       = mem.mem_ready ? S_FETCH : S_EXEC;
          end
          OP_ST, OP_STR: begin
            mem_req        = 1'b1;
            mem_we         = 1'b1;
            mem_addr_sel   = (opcode == OP_ST) ? 2'd1 : 2'd2;
            rf_rq_rd       = (opcode == OP_STR);
            rf_rp_addr_sel = 1'b1;
            rf_rp_rd       = 1'b1;
            state_d        = mem.mem_ready ? S_FETCH : S_EXEC;
          end
          OP_LDI, OP_STI: begin
            // First access fetches the pointer into temp.
            mem_req      = 1'b1;
            mem_addr_sel = 2'd1;
            temp_ld      = mem.mem_ready;
            state_d      = mem.mem_ready ? S_EXEC2 : S_EXEC;
          end
          OP_HLT: state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXEC2: begin
        state_d = S_FETCH;
        case (opcode)
          OP_JSR: begin
            pc_ld = 1'b1;
            if (ir[11]) pc_sel = 2'd1;
            else begin
              pc_sel   = 2'd2;
              rf_rq_rd = 1'b1;
            end
          end
          OP_LDI: begin
            mem_req       = 1'b1;
            mem_addr_sel  = 2'd3;
            rf_w_data_sel = 2'd1;
            rf_w_wr       = mem.mem_ready;
            nzp_ld        = mem.mem_ready;
            state_d       = mem.mem_ready ? S_FETCH : S_EXEC2;
          end
          OP_STI: begin
            mem_req        = 1'b1;
            mem_we         = 1'b1;
            mem_addr_sel   = 2'd3;
            rf_rp_addr_sel = 1'b1;
            rf_rp_rd       = 1'b1;
            state_d        = mem.mem_ready ? S_FETCH : S_EXEC2;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
        if (run) state_d = S_FETCH;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_INIT;
    endcase

    // A completing access always wins over the timeout.
    if (stalled && timeout_hit) state_d = S_FAULT;
  end

`ifdef PUNC_CTRL_PERF_EN
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    stall_count_d = stall_count_q;
    // An EXEC exit is a retiring instruction; a timeout into FAULT is not.
    if (state_q == S_EXEC && state_d != S_EXEC && state_d != S_FAULT)
      instr_count_d = instr_count_q + CNT_W'(1);
    if (stalled)
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      instr_count_q <= instr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign instr_count = instr_count_q;
  assign stall_count = stall_count_q;
`else
  assign instr_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_punc_mc_control.sv
// -----------------------------------------------------------------------------
// tb_punc_mc_control
//   Directed bench for punc_mc_control. The stimulus process drives one cycle
//   at a time and pushes the hand-written expected control vector (or counter
//   value) for that cycle into a queue; a monitor on the falling edge pops and
//   compares every entry against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_punc_mc_control;

  typedef struct packed {
    logic       ir_clr, ir_ld, pc_clr, pc_ld, pc_inc;
    logic [1:0] pc_sel;
    logic       mem_req, mem_we;
    logic [1:0] mem_addr_sel, rf_w_data_sel;
    logic       rf_w_addr_sel, rf_rp_addr_sel, rf_w_wr, rf_rp_rd, rf_rq_rd;
    logic       temp_ld, nzp_ld, nzp_clr;
    logic [1:0] alu_sel;
    logic       alu_in_a, halted, fault;
  } ctl_t;

  typedef struct packed {
    logic [1:0]  kind;  // 0 control vector, 1 instr_count, 2 stall_count
    ctl_t        exp;
    logic [31:0] val;
  } item_t;

`ifdef PUNC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        nzp_match, run;
  logic        ir_clr, ir_ld, pc_clr, pc_ld, pc_inc;
  logic [1:0]  pc_sel, rf_w_data_sel, alu_sel;
  logic        rf_w_addr_sel, rf_rp_addr_sel, rf_w_wr, rf_rp_rd, rf_rq_rd;
  logic        temp_ld, nzp_ld, nzp_clr, alu_in_a, halted, fault;
  logic [31:0] instr_count, stall_count;
  ctl_t        obs;

  punc_mc_control_if mem_if ();

  punc_mc_control #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ir(ir), .nzp_match(nzp_match), .run(run),
    .mem(mem_if),
    .ir_clr(ir_clr), .ir_ld(ir_ld), .pc_clr(pc_clr), .pc_ld(pc_ld),
    .pc_inc(pc_inc), .pc_sel(pc_sel), .rf_w_data_sel(rf_w_data_sel),
    .rf_w_addr_sel(rf_w_addr_sel), .rf_rp_addr_sel(rf_rp_addr_sel),
    .rf_w_wr(rf_w_wr), .rf_rp_rd(rf_rp_rd), .rf_rq_rd(rf_rq_rd),
    .temp_ld(temp_ld), .nzp_ld(nzp_ld), .nzp_clr(nzp_clr),
    .alu_sel(alu_sel), .alu_in_a(alu_in_a), .halted(halted), .fault(fault),
    .instr_count(instr_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign obs = {ir_clr, ir_ld, pc_clr, pc_ld, pc_inc, pc_sel,
                mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr_sel,
                rf_w_data_sel, rf_w_addr_sel, rf_rp_addr_sel, rf_w_wr,
                rf_rp_rd, rf_rq_rd, temp_ld, nzp_ld, nzp_clr, alu_sel,
                alu_in_a, halted, fault};

  string name_q[$];
  item_t item_q[$];
  int    checks = 0;
  int    errors = 0;

  // Monitor: compares everything queued for the current cycle.
  always @(negedge clk) begin
    while (item_q.size() > 0) begin
      string nm;
      item_t it;
      nm = name_q.pop_front();
      it = item_q.pop_front();
      checks++;
      if (it.kind == 2'd0) begin
        if (obs !== it.exp) begin
          errors++;
          $display("FAIL %s: ctl got %07h expected %07h", nm, obs, it.exp);
        end else
          $display("ok   %s: ctl %07h", nm, obs);
      end else begin
        logic [31:0] act;
        act = (it.kind == 2'd1) ? instr_count : stall_count;
        if (act !== it.val) begin
          errors++;
          $display("FAIL %s: count got %0d expected %0d", nm, act, it.val);
        end else
          $display("ok   %s: count %0d", nm, act);
      end
    end
  end

  function automatic ctl_t f_init();
    ctl_t e = '0;
    e.pc_clr = 1'b1; e.ir_clr = 1'b1; e.nzp_clr = 1'b1;
    return e;
  endfunction

  function automatic ctl_t f_fetch(input bit rdy);
    ctl_t e = '0;
    e.mem_req = 1'b1; e.ir_ld = rdy; e.pc_inc = rdy;
    return e;
  endfunction

  task automatic push_ctl(input string nm, input ctl_t e);
    item_t it;
    it = '0; it.kind = 2'd0; it.exp = e;
    name_q.push_back(nm); item_q.push_back(it);
  endtask

  task automatic push_cnt(input string nm, input logic [1:0] kind,
                          input logic [31:0] v);
    item_t it;
    it = '0; it.kind = kind; it.val = PERF ? v : 32'd0;
    name_q.push_back(nm); item_q.push_back(it);
  endtask

  // Queue the expectation for the current cycle, then advance one cycle.
  task automatic cyc(input string nm, input ctl_t e);
    push_ctl(nm, e);
    @(posedge clk); #1;
  endtask

  // Fetch (zero wait) plus decode of a new instruction.
  task automatic fetch_decode(input string nm, input logic [15:0] instr);
    ir = instr;
    mem_if.mem_ready = 1'b1;
    cyc({nm, "_fetch"}, f_fetch(1'b1));
    cyc({nm, "_decode"}, ctl_t'('0));
  endtask

  initial begin
    ctl_t e;
    rst = 1'b1; ir = 16'h0000; nzp_match = 1'b0; run = 1'b0;
    mem_if.mem_ready = 1'b0;
    @(posedge clk); #1;

    // Reset behaviour
    push_cnt("rst_instr", 2'd1, 0);
    push_cnt("rst_stall", 2'd2, 0);
    cyc("rst_held", f_init());
    rst = 1'b0;
    cyc("rst_released", f_init());
    cyc("fetch_wait0", f_fetch(1'b0));
    rst = 1'b1;  // mid-access, no clock edge before the check
    cyc("rst_mid_fetch", f_init());
    rst = 1'b0;
    cyc("init_again", f_init());

    // LDI 0xA203, two wait cycles on each data access
    fetch_decode("ldi", 16'hA203);
    mem_if.mem_ready = 1'b0;
    e = '0; e.mem_req = 1'b1; e.mem_addr_sel = 2'd1;
    cyc("ldi_exec_w1", e);
    cyc("ldi_exec_w2", e);
    mem_if.mem_ready = 1'b1; e.temp_ld = 1'b1;
    cyc("ldi_exec_rdy", e);
    mem_if.mem_ready = 1'b0;
    e = '0; e.mem_req = 1'b1; e.mem_addr_sel = 2'd3; e.rf_w_data_sel = 2'd1;
    cyc("ldi_exec2_w1", e);
    cyc("ldi_exec2_w2", e);
    mem_if.mem_ready = 1'b1; e.rf_w_wr = 1'b1; e.nzp_ld = 1'b1;
    cyc("ldi_exec2_rdy", e);
    push_cnt("ldi_instr", 2'd1, 1);
    push_cnt("ldi_stall", 2'd2, 4);

    // ADD R1,R2,#5 ; run pulse during DECODE must be ignored
    ir = 16'h12A5;
    cyc("add_fetch", f_fetch(1'b1));
    run = 1'b1;
    cyc("add_decode_run", ctl_t'('0));
    run = 1'b0;
    e = '0; e.rf_w_wr = 1'b1; e.nzp_ld = 1'b1; e.rf_rq_rd = 1'b1;
    e.alu_in_a = 1'b1;
    cyc("add_exec", e);

    // AND R0,R1,R2 (register form)
    fetch_decode("and", 16'h5042);
    e = '0; e.rf_w_wr = 1'b1; e.nzp_ld = 1'b1; e.rf_rq_rd = 1'b1;
    e.rf_rp_rd = 1'b1; e.alu_sel = 2'd1;
    cyc("and_exec", e);

    // NOT R1,R1
    fetch_decode("not", 16'h927F);
    e = '0; e.alu_sel = 2'd2; e.rf_rq_rd = 1'b1; e.rf_w_wr = 1'b1;
    e.nzp_ld = 1'b1;
    cyc("not_exec", e);

    // BR taken / not taken
    fetch_decode("brt", 16'h0E05);
    nzp_match = 1'b1;
    e = '0; e.pc_ld = 1'b1;
    cyc("br_taken", e);
    fetch_decode("brn", 16'h0E05);
    nzp_match = 1'b0;
    cyc("br_not_taken", ctl_t'('0));

    // JMP R7
    fetch_decode("jmp", 16'hC1C0);
    e = '0; e.rf_rq_rd = 1'b1; e.pc_ld = 1'b1; e.pc_sel = 2'd2;
    cyc("jmp_exec", e);

    // LEA R1,#5
    fetch_decode("lea", 16'hE205);
    e = '0; e.rf_w_data_sel = 2'd3; e.rf_w_wr = 1'b1; e.nzp_ld = 1'b1;
    cyc("lea_exec", e);

    // LD R1,#3
    fetch_decode("ld", 16'h2203);
    e = '0; e.mem_req = 1'b1; e.mem_addr_sel = 2'd1; e.rf_w_data_sel = 2'd1;
    e.rf_w_wr = 1'b1; e.nzp_ld = 1'b1;
    cyc("ld_exec", e);

    // STR R1,R2,#3
    fetch_decode("str", 16'h7283);
    e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr_sel = 2'd2;
    e.rf_rp_addr_sel = 1'b1; e.rf_rp_rd = 1'b1; e.rf_rq_rd = 1'b1;
    cyc("str_exec", e);

    // JSR #5 then JSRR R2
    fetch_decode("jsr", 16'h4805);
    e = '0; e.rf_w_data_sel = 2'd2; e.rf_w_addr_sel = 1'b1; e.rf_w_wr = 1'b1;
    cyc("jsr_exec", e);
    e = '0; e.pc_ld = 1'b1; e.pc_sel = 2'd1;
    cyc("jsr_exec2", e);
    fetch_decode("jsrr", 16'h4080);
    e = '0; e.rf_w_data_sel = 2'd2; e.rf_w_addr_sel = 1'b1; e.rf_w_wr = 1'b1;
    cyc("jsrr_exec", e);
    e = '0; e.pc_ld = 1'b1; e.pc_sel = 2'd2; e.rf_rq_rd = 1'b1;
    cyc("jsrr_exec2", e);

    // HLT: stays halted until run
    fetch_decode("hlt", 16'hF025);
    cyc("hlt_exec", ctl_t'('0));
    push_cnt("hlt_instr", 2'd1, 13);
    push_cnt("hlt_stall", 2'd2, 4);
    e = '0; e.halted = 1'b1;
    for (int i = 0; i < 5; i++) cyc($sformatf("halt_idle%0d", i), e);
    mem_if.mem_ready = 1'b0;
    run = 1'b1;
    cyc("halt_run", e);
    run = 1'b0;

    // Timeout: FETCH stuck for 16 cycles, FAULT on the 17th
    for (int i = 1; i <= 16; i++)
      cyc($sformatf("to_fetch%0d", i), f_fetch(1'b0));
    e = '0; e.fault = 1'b1;
    cyc("fault_entered", e);
    run = 1'b1;
    mem_if.mem_ready = 1'b1;
    cyc("fault_run1", e);
    cyc("fault_run2", e);
    push_cnt("fault_instr", 2'd1, 13);
    push_cnt("fault_stall", 2'd2, 20);
    cyc("fault_run3", e);
    run = 1'b0;

    // Only reset recovers
    rst = 1'b1;
    push_cnt("rec_instr", 2'd1, 0);
    push_cnt("rec_stall", 2'd2, 0);
    cyc("fault_rst", f_init());
    rst = 1'b0;
    cyc("rec_init", f_init());
    cyc("rec_fetch", f_fetch(1'b1));

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/punc_mc_control.md
# punc_mc_control

Multicycle control unit for the PUnC LC3 processor, generalised for memories with variable latency. It decodes `ir`, sequences FETCH/DECODE/EXECUTE/EXECUTE2 and drives the datapath control strobes. Every memory access is held with a `mem_req`/`mem_ready` handshake. A wait timeout traps the core in a FAULT state, and an optional instruction/stall counter pair can be compiled in. It sits between the PUnC datapath and its memory wrapper.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum wait cycles per memory access before FAULT; 0 disables the timeout.
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ir` in 16: instruction register contents.
- `nzp_match` in 1: condition codes match `ir[11:9]`.
- `mem_ready` in 1: memory completes the current access this cycle.
- `run` in 1: resume from HALT.
- `ir_clr`, `ir_ld`, `pc_clr`, `pc_ld`, `pc_inc` out 1: IR and PC controls.
- `pc_sel` out 2: PC source. 0 = PC+off9, 1 = PC+off11, 2 = Rq.
- `mem_req`, `mem_we` out 1: access request and write enable.
- `mem_addr_sel` out 2: address source. 0 = PC, 1 = PC+off9, 2 = Rq+off6, 3 = temp.
- `rf_w_data_sel` out 2: write data. 0 = ALU, 1 = mem, 2 = PC, 3 = PC+off9.
- `rf_w_addr_sel` out 1: write address. 0 = `ir[11:9]`, 1 = R7.
- `rf_rp_addr_sel` out 1: Rp address. 0 = `ir[2:0]`, 1 = `ir[11:9]`.
- `rf_w_wr`, `rf_rp_rd`, `rf_rq_rd` out 1: register file strobes. Rq is always `ir[8:6]`.
- `temp_ld`, `nzp_ld`, `nzp_clr` out 1: temp register and NZP controls.
- `alu_sel` out 2: 0 = ADD, 1 = AND, 2 = NOT_B.
- `alu_in_a` out 1: ALU A input. 0 = Rp, 1 = imm5.
- `halted`, `fault` out 1: status.
- `instr_count`, `stall_count` out `CNT_W`: performance counters.

## Operation
- States: INIT, FETCH, DECODE, EXEC, EXEC2, HALT, FAULT.
- INIT: assert `pc_clr`, `ir_clr`, `nzp_clr`. Next state is FETCH.
- FETCH: `mem_req=1`, `mem_addr_sel=0`. `ir_ld` and `pc_inc` are asserted only in the cycle `mem_ready=1`, which also moves to DECODE.
- DECODE: no outputs asserted. Next state is EXEC.
- Opcodes in `ir[15:12]`: BR 0000, ADD 0001, LD 0010, ST 0011, JSR 0100, AND 0101, LDR 0110, STR 0111, NOT 1001, LDI 1010, STI 1011, JMP 1100, LEA 1110, HLT 1111. Opcodes 1000 and 1101 execute as NOPs.
- ADD/AND: `rf_w_wr`, `nzp_ld`, `rf_rq_rd`.
  - `ir[5]=0`: `rf_rp_rd=1`, `alu_in_a=0`.
  - `ir[5]=1`: `alu_in_a=1`.
- NOT: `alu_sel=2`, `rf_rq_rd`, `rf_w_wr`, `nzp_ld`.
- LEA: `rf_w_data_sel=3`, `rf_w_wr`, `nzp_ld`.
- BR: `pc_ld` with `pc_sel=0` only if `nzp_match`.
- JMP: `rf_rq_rd`, `pc_ld`, `pc_sel=2`.
- JSR:
  - EXEC: R7 <- PC (`rf_w_data_sel=2`, `rf_w_addr_sel=1`, `rf_w_wr=1`).
  - EXEC2: `pc_ld`, with `pc_sel=1` if `ir[11]`, else `pc_sel=2` with `rf_rq_rd`.
- LD/LDR: memory read with `mem_addr_sel` 1 or 2 (LDR adds `rf_rq_rd`). `rf_w_data_sel=1`; `rf_w_wr` and `nzp_ld` are asserted only in the `mem_ready` cycle.
- ST/STR: `mem_we=1`, `rf_rp_addr_sel=1`, `rf_rp_rd=1`, with `mem_addr_sel` 1 or 2.
- LDI/STI:
  - EXEC: read at PC+off9, `temp_ld` asserted in the `mem_ready` cycle.
  - EXEC2, LDI: read at temp; the write to DR plus `nzp_ld` follows the LD rules.
  - EXEC2, STI: write SR (`rf_rp_addr_sel=1`) at temp.
- Leaving EXEC:
  - JSR/LDI/STI go to EXEC2.
  - HLT goes to HALT.
  - All others go to FETCH.
- EXEC2 returns to FETCH after the access completes (immediately for JSR).
- HALT: `halted=1`. `run=1` moves to FETCH.
- FAULT: `fault=1`, no other outputs asserted. It is left only by `rst`.
- Timeout: a `wait_cnt` counter counts cycles with `mem_req=1` and `mem_ready=0`, and clears on every state change.
  - If `wait_cnt == TIMEOUT_CYCLES-1` while `mem_ready=0`, the next state is FAULT.
  - The `mem_ready=1` check has priority over the timeout.

## Timing
- Reset: while `rst` is high, and immediately on its assertion (asynchronous), state = INIT.
  - Outputs in INIT: `pc_clr=ir_clr=nzp_clr=1`, all others 0.
  - Counters and `wait_cnt` are cleared.
- Reset mid-access drops `mem_req` combinationally.
- All outputs are combinational from state, `ir`, `nzp_match` and `mem_ready`.
- Latency with zero-wait memory (`mem_ready` tied 1):
  - 3 cycles: ALU ops, BR, JMP, LEA, LD, ST.
  - 4 cycles: JSR, LDI, STI.
  - Each wait cycle adds 1.
- Write strobes (`rf_w_wr`, `temp_ld`, `ir_ld`, `pc_inc`, `nzp_ld` on loads) never assert in a cycle with `mem_ready=0`.
- `mem_we` and the address stay stable for the whole request.
- `run` is sampled only in HALT. A `run` pulse in any other state is ignored.

## Configuration
- `PUNC_CTRL_PERF_EN` defined:
  - `instr_count` increments in every EXEC-exit cycle, HLT included.
  - `stall_count` increments in every cycle with `mem_req=1` and `mem_ready=0`.
  - Both wrap modulo 2^`CNT_W` and clear on `rst`.
- Undefined: both ports remain and are tied to 0; no counter flops are built.

## Test plan
- Reset mid-FETCH with `mem_ready=0`: `mem_req` -> 0 with no clock edge; outputs show INIT values; FETCH follows 1 cycle after `rst` falls.
- ADD R1,R2,#5 (0x12A5) with `mem_ready` tied 1: EXEC cycle 3 shows `rf_w_wr=1`, `alu_in_a=1`, `nzp_ld=1`, `alu_sel=0`; FETCH on cycle 4.
- LDI (0xA203) with `mem_ready` delayed 2 cycles per access: `temp_ld` exactly 1 cycle, `rf_w_wr` exactly 1 cycle; total 8 cycles; `stall_count=4`.
- JSR 0x4805: EXEC writes R7; EXEC2 `pc_ld=1`, `pc_sel=1`. JSRR 0x4080: EXEC2 `pc_sel=2`, `rf_rq_rd=1`.
- `mem_ready` held 0 in FETCH with `TIMEOUT_CYCLES=16`: FAULT entered on the 17th cycle, `fault=1`; `run` has no effect; only `rst` recovers.
- HLT 0xF025: `halted=1`; 5 idle cycles with no change; `run` pulse -> FETCH next cycle; `instr_count` incremented once for the HLT.
